// File: rtl/mac_vec_pipe.sv
// Pipelined dot-product MAC: operand register, multiply stage, saturating accumulate stage.
// Ready/valid on both sides; the vector's signed/unsigned mode is latched with its first term.
module mac_vec_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int MUL_WIDTH  = 32,
   parameter int ACC_WIDTH  = 40,
   parameter int VEC_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  signed_mode,
   input  logic [DATA_WIDTH-1:0] A_in,
   input  logic [DATA_WIDTH-1:0] B_in,
   input  logic                  clr,
   output logic [MUL_WIDTH-1:0]  mul_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic                  sat_flag
);

   localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
   localparam int XW = ACC_WIDTH + 1 - MUL_WIDTH;
   localparam int PW = 2 * DATA_WIDTH + 2;

   logic                  rdy_q, rdy_d;
   logic [CW-1:0]         in_cnt_q, in_cnt_d;
   logic                  mode_q, mode_d;
   logic                  i_valid_q, i_valid_d;
   logic                  i_sgn_q, i_sgn_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_sgn_q, m_sgn_d;
   logic [MUL_WIDTH-1:0]  mul_q, mul_d;
   logic [CW-1:0]         term_cnt_q, term_cnt_d;
   logic [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                  vec_sat_q, vec_sat_d;
   logic                  out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
   logic                  sat_q, sat_d;

   logic                  stall, accept, term_sgn, clamp_now;
   logic [PW-1:0]         a_ext, b_ext, prod_full;
   logic [ACC_WIDTH:0]    mul_ext, base, sum;
   logic [ACC_WIDTH-1:0]  clamped;

   always_comb begin
      stall    = out_valid_q & ~out_ready;
      in_ready = rdy_q & ~stall & ~clr;
      accept   = in_valid & in_ready;
      term_sgn = (in_cnt_q == '0) ? signed_mode : mode_q;

      // One extra bit of extension lets a single signed multiply serve both modes.
      a_ext     = {{(DATA_WIDTH + 2){a_q[DATA_WIDTH-1] & i_sgn_q}}, a_q};
      b_ext     = {{(DATA_WIDTH + 2){b_q[DATA_WIDTH-1] & i_sgn_q}}, b_q};
      prod_full = PW'($signed(a_ext) * $signed(b_ext));

      mul_ext = {{XW{mul_q[MUL_WIDTH-1] & m_sgn_q}}, mul_q};
      base    = (term_cnt_q == '0) ? '0 : {acc_q[ACC_WIDTH-1] & m_sgn_q, acc_q};
      sum     = base + mul_ext;

      clamped   = sum[ACC_WIDTH-1:0];
      clamp_now = 1'b0;
      if (m_sgn_q) begin
         if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            clamp_now = 1'b1;
            clamped   = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end else if (sum[ACC_WIDTH]) begin
         clamp_now = 1'b1;
         clamped   = '1;
      end

      rdy_d       = 1'b1;
      in_cnt_d    = in_cnt_q;
      mode_d      = mode_q;
      i_valid_d   = i_valid_q;
      i_sgn_d     = i_sgn_q;
      a_d         = a_q;
      b_d         = b_q;
      m_valid_d   = m_valid_q;
      m_sgn_d     = m_sgn_q;
      mul_d       = mul_q;
      term_cnt_d  = term_cnt_q;
      acc_d       = acc_q;
      vec_sat_d   = vec_sat_q;
      out_valid_d = out_valid_q;
      acc_out_d   = acc_out_q;
      sat_d       = sat_q;

      if (accept) begin
         in_cnt_d = (in_cnt_q == LAST) ? '0 : in_cnt_q + 1'b1;
         mode_d   = term_sgn;
         i_sgn_d  = term_sgn;
         a_d      = A_in;
         b_d      = B_in;
      end

      if (out_valid_q & out_ready)
         out_valid_d = 1'b0;

      // Flush drops everything in flight but leaves a finished result untouched.
      if (clr) begin
         in_cnt_d   = '0;
         i_valid_d  = 1'b0;
         m_valid_d  = 1'b0;
         term_cnt_d = '0;
         acc_d      = '0;
         vec_sat_d  = 1'b0;
      end else if (!stall) begin
         i_valid_d = accept;
         m_valid_d = i_valid_q;
         if (i_valid_q) begin
            mul_d   = prod_full[MUL_WIDTH-1:0];
            m_sgn_d = i_sgn_q;
         end
         if (m_valid_q) begin
            acc_d = clamped;
            if (term_cnt_q == LAST) begin
               term_cnt_d  = '0;
               vec_sat_d   = 1'b0;
               acc_out_d   = clamped;
               sat_d       = vec_sat_q | clamp_now;
               out_valid_d = 1'b1;
            end else begin
               term_cnt_d = term_cnt_q + 1'b1;
               vec_sat_d  = vec_sat_q | clamp_now;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q       <= 1'b0;
         in_cnt_q    <= '0;
         mode_q      <= 1'b0;
         i_valid_q   <= 1'b0;
         i_sgn_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         m_valid_q   <= 1'b0;
         m_sgn_q     <= 1'b0;
         mul_q       <= '0;
         term_cnt_q  <= '0;
         acc_q       <= '0;
         vec_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
         acc_out_q   <= '0;
         sat_q       <= 1'b0;
      end else begin
         rdy_q       <= rdy_d;
         in_cnt_q    <= in_cnt_d;
         mode_q      <= mode_d;
         i_valid_q   <= i_valid_d;
         i_sgn_q     <= i_sgn_d;
         a_q         <= a_d;
         b_q         <= b_d;
         m_valid_q   <= m_valid_d;
         m_sgn_q     <= m_sgn_d;
         mul_q       <= mul_d;
         term_cnt_q  <= term_cnt_d;
         acc_q       <= acc_d;
         vec_sat_q   <= vec_sat_d;
         out_valid_q <= out_valid_d;
         acc_out_q   <= acc_out_d;
         sat_q       <= sat_d;
      end
   end

   assign mul_out   = mul_q;
   assign out_valid = out_valid_q;
   assign acc_out   = acc_out_q;
   assign sat_flag  = sat_q;

endmodule
